// File: rtl/sec32_check_encoder.sv
// sec32_check_encoder: transmit-side SEC check-bit encoder for the 32-bit c1355-class codeword.
// Valid/ready pipeline of 1 or 2 stages, with a one-shot single-bit fault injector at the output stage.
module sec32_check_encoder #(
   parameter int PIPE_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [7:0]       out_check,
   input  logic             inj_arm,
   input  logic [5:0]       inj_pos,
   output logic             inj_busy,
   output logic [CNT_W-1:0] word_cnt
);
   // Entry k lists the data bits whose XOR forms check bit k.
   localparam logic [7:0][31:0] CHECK_MASK = {
      32'h8888_F0F0, 32'h4444_0F0F, 32'h2222_FF00, 32'h1111_00FF,
      32'hF0F0_8888, 32'h0F0F_4444, 32'hFF00_2222, 32'h00FF_1111
   };

   typedef enum logic {IDLE, ARMED} inj_state_t;

   inj_state_t  inj_state;
   logic [5:0]  inj_pos_q;
   logic        accept;
   logic        out_adv;
   logic        acc_flip;
   logic [5:0]  acc_pos;
   logic        feed_valid;
   logic [31:0] feed_data;
   logic [7:0]  feed_check;
   logic        feed_flip;
   logic [5:0]  feed_pos;
   logic [39:0] flip_mask;

   assign accept   = in_valid && in_ready;
   assign out_adv  = !out_valid || out_ready;
   assign inj_busy = (inj_state == ARMED);
   assign acc_flip = (inj_state == ARMED) || inj_arm;
   assign acc_pos  = (inj_state == ARMED) ? inj_pos_q : inj_pos;

   generate
      if (PIPE_DEPTH == 2) begin : g_two_stage
         logic            s1_valid;
         logic [31:0]     s1_data;
         logic [7:0][7:0] s1_part;
         logic            s1_flip;
         logic [5:0]      s1_pos;
         logic [7:0][7:0] part;

         // Per-nibble partial parity of each check group, reduced in the output stage.
         always_comb begin
            part = '0;
            for (int k = 0; k < 8; k++) begin
               for (int n = 0; n < 8; n++) begin
                  part[k][n] = ^(in_data[4*n +: 4] & CHECK_MASK[k][4*n +: 4]);
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_valid <= 1'b0;
               s1_data  <= '0;
               s1_part  <= '0;
               s1_flip  <= 1'b0;
               s1_pos   <= '0;
            end else if (in_ready) begin
               s1_valid <= in_valid;
               if (in_valid) begin
                  s1_data <= in_data;
                  s1_part <= part;
                  s1_flip <= acc_flip;
                  s1_pos  <= acc_pos;
               end
            end
         end

         always_comb begin
            feed_check = '0;
            for (int k = 0; k < 8; k++) begin
               feed_check[k] = ^s1_part[k];
            end
         end

         assign in_ready   = !s1_valid || out_adv;
         assign feed_valid = s1_valid;
         assign feed_data  = s1_data;
         assign feed_flip  = s1_flip;
         assign feed_pos   = s1_pos;
      end else begin : g_one_stage
         always_comb begin
            feed_check = '0;
            for (int k = 0; k < 8; k++) begin
               feed_check[k] = ^(in_data & CHECK_MASK[k]);
            end
         end

         assign in_ready   = out_adv;
         assign feed_valid = in_valid;
         assign feed_data  = in_data;
         assign feed_flip  = acc_flip;
         assign feed_pos   = acc_pos;
      end
   endgenerate

   always_comb begin
      flip_mask = '0;
      if (feed_flip && (feed_pos < 6'd40)) begin
         flip_mask[feed_pos] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_check <= '0;
      end else if (out_adv) begin
         out_valid <= feed_valid;
         if (feed_valid) begin
            {out_check, out_data} <= {feed_check, feed_data} ^ flip_mask;
         end
      end
   end

   // An arm coinciding with an accept is consumed by that word and never reaches ARMED.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inj_state <= IDLE;
         inj_pos_q <= '0;
      end else begin
         case (inj_state)
            IDLE: begin
               if (inj_arm && !accept) begin
                  inj_state <= ARMED;
                  inj_pos_q <= inj_pos;
               end
            end
            ARMED: begin
               if (accept) begin
                  inj_state <= IDLE;
               end
            end
            default: inj_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
      end else if (accept) begin
         word_cnt <= word_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_sec32_check_encoder.sv
// tb_sec32_check_encoder: directed and randomized checks of the SEC encoder against a bench-side
// model built from the per-check-bit coverage rules, with a scoreboard for order and injection.
module tb_sec32_check_encoder;
   localparam int PD = 2;

   typedef struct packed {
      logic [39:0] word;
      logic        clean;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic [7:0]  out_check;
   logic        inj_arm = 1'b0;
   logic [5:0]  inj_pos = '0;
   logic        inj_busy;
   logic [15:0] word_cnt;

   int          checks = 0;
   int          errors = 0;
   int          tick_no = 0;
   int          stall_from = -1;
   int          stall_to = -1;
   int          arm_tick = -1;
   logic [5:0]  arm_pos = '0;
   int          first_acc_tick = -1;
   int          first_out_tick = -1;
   int          last_out_tick = -1;
   int          out_count = 0;
   int          accept_count = 0;
   bit          model_armed = 1'b0;
   logic [5:0]  model_pos = '0;
   bit          prev_stall = 1'b0;
   logic [39:0] prev_word = '0;
   bit          saw_ready_low = 1'b0;
   logic [31:0] src_q[$];
   exp_t        exp_q[$];
   logic [39:0] obs_q[$];

   sec32_check_encoder #(.PIPE_DEPTH(PD), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_check (out_check),
      .inj_arm   (inj_arm),
      .inj_pos   (inj_pos),
      .inj_busy  (inj_busy),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Check bit k covers data bit i: the low half follows a stride/range rule, the high half another.
   function automatic bit covers(input int k, input int i);
      case (k)
         0:       return (i < 16) ? (i % 4 == 0) : (i <= 23);
         1:       return (i < 16) ? (i % 4 == 1) : (i >= 24);
         2:       return (i < 16) ? (i % 4 == 2) : (i <= 19 || (i >= 24 && i <= 27));
         3:       return (i < 16) ? (i % 4 == 3) : ((i >= 20 && i <= 23) || i >= 28);
         4:       return (i < 16) ? (i <= 7) : (i % 4 == 0);
         5:       return (i < 16) ? (i >= 8) : (i % 4 == 1);
         6:       return (i < 16) ? (i % 8 < 4) : (i % 4 == 2);
         default: return (i < 16) ? (i % 8 >= 4) : (i % 4 == 3);
      endcase
   endfunction

   function automatic logic [7:0] model_check(input logic [31:0] d);
      logic [7:0] c;
      c = '0;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 32; i++) begin
            if (covers(k, i) && d[i]) c[k] = ~c[k];
         end
      end
      return c;
   endfunction

   function automatic logic [39:0] obs_at(input int idx);
      if (idx < obs_q.size()) return obs_q[idx];
      return 'x;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample one cycle just before the rising edge, then return at the following falling edge.
   task automatic tick();
      bit          acc;
      bit          fl;
      logic [5:0]  p;
      logic [39:0] w;
      exp_t        e;
      logic [39:0] obs;
      #4;
      acc = in_valid && in_ready;
      check("inj_busy", inj_busy, model_armed);
      if (prev_stall) begin
         check("hold_valid", out_valid, 1'b1);
         check("hold_word", {out_check, out_data}, prev_word);
      end
      if (!out_ready && in_valid && !in_ready) saw_ready_low = 1'b1;
      if (out_valid && out_ready) begin
         obs = {out_check, out_data};
         check("scoreboard_nonempty", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("codeword", obs, e.word);
            if (e.clean) check("syndrome", model_check(obs[31:0]) ^ obs[39:32], 8'h00);
         end
         obs_q.push_back(obs);
         out_count++;
         if (first_out_tick < 0) first_out_tick = tick_no;
         last_out_tick = tick_no;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_check, out_data};
      if (acc) begin
         fl = model_armed || inj_arm;
         p  = model_armed ? model_pos : inj_pos;
         w  = {model_check(in_data), in_data};
         if (fl && p < 40) w[p] = ~w[p];
         e.word  = w;
         e.clean = !(fl && p < 40);
         exp_q.push_back(e);
         if (src_q.size() != 0) void'(src_q.pop_front());
         accept_count++;
         if (first_acc_tick < 0) first_acc_tick = tick_no;
      end
      if (acc) model_armed = 1'b0;
      else if (inj_arm && !model_armed) begin
         model_armed = 1'b1;
         model_pos   = inj_pos;
      end
      @(negedge clk);
      tick_no++;
   endtask

   task automatic apply_stimulus();
      in_valid  = (src_q.size() != 0);
      in_data   = (src_q.size() != 0) ? src_q[0] : 32'h0;
      out_ready = !(tick_no >= stall_from && tick_no < stall_to);
      inj_arm   = (tick_no == arm_tick);
      inj_pos   = arm_pos;
      tick();
   endtask

   task automatic pump(input int budget);
      int n;
      n = 0;
      while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         apply_stimulus();
         n++;
      end
      check("drain_in_budget", n < budget, 1'b1);
      in_valid = 1'b0;
      inj_arm  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic clear_model();
      src_q.delete();
      exp_q.delete();
      obs_q.delete();
      model_armed = 1'b0;
      accept_count = 0;
      prev_stall = 1'b0;
      stall_from = -1;
      stall_to = -1;
      arm_tick = -1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      inj_arm = 1'b0;
      out_ready = 1'b1;
      clear_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready_after_reset", in_ready, 1'b1);
      @(negedge clk);
      tick_no++;
   endtask

   initial begin
      logic [31:0] d;
      int          out_before;

      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_check", out_check, 8'h00);
      check("rst_inj_busy", inj_busy, 1'b0);
      check("rst_word_cnt", word_cnt, 16'd0);
      do_reset();

      $display("[TB] known check-bit vectors");
      src_q = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
      pump(100);
      check("t1_count", obs_q.size(), 4);
      check("t1_zero", obs_at(0), {8'h00, 32'h0000_0000});
      check("t1_bit0", obs_at(1), {8'h51, 32'h0000_0001});
      check("t1_bit31", obs_at(2), {8'h8A, 32'h8000_0000});
      check("t1_ones", obs_at(3), {8'h00, 32'hFFFF_FFFF});

      $display("[TB] 100-word random stream");
      do_reset();
      first_acc_tick = -1;
      first_out_tick = -1;
      out_count = 0;
      for (int i = 0; i < 100; i++) src_q.push_back($urandom());
      pump(400);
      check("t2_latency", first_out_tick - first_acc_tick, PD);
      check("t2_out_count", out_count, 100);
      check("t2_back_to_back", last_out_tick - first_out_tick, 99);
      check("t2_word_cnt", word_cnt, 16'd100);

      $display("[TB] backpressure mid-stream");
      saw_ready_low = 1'b0;
      obs_q.delete();
      for (int i = 0; i < 20; i++) src_q.push_back($urandom());
      stall_from = tick_no + 6;
      stall_to   = tick_no + 11;
      pump(400);
      check("t3_in_ready_dropped", saw_ready_low, 1'b1);
      check("t3_out_count", obs_q.size(), 20);
      check("t3_word_cnt", word_cnt, accept_count);

      $display("[TB] injection on check bit 3");
      obs_q.delete();
      arm_tick = tick_no;
      arm_pos  = 6'd35;
      apply_stimulus();
      inj_arm = 1'b0;
      check("t4_busy_set", inj_busy, 1'b1);
      src_q = '{32'h0000_0001, 32'h0000_0001};
      pump(100);
      check("t4_flipped", obs_at(0), {8'h59, 32'h0000_0001});
      check("t4_next_clean", obs_at(1), {8'h51, 32'h0000_0001});
      check("t4_busy_clear", inj_busy, 1'b0);

      $display("[TB] injection armed with the accept");
      obs_q.delete();
      arm_tick = tick_no;
      arm_pos  = 6'd7;
      src_q = '{32'h0000_0000, 32'h0000_0000};
      pump(100);
      check("t5_flipped", obs_at(0), {8'h00, 32'h0000_0080});
      check("t5_next_clean", obs_at(1), {8'h00, 32'h0000_0000});
      check("t5_busy_clear", inj_busy, 1'b0);

      $display("[TB] out-of-range injection position");
      obs_q.delete();
      d = $urandom();
      arm_tick = tick_no;
      arm_pos  = 6'd50;
      src_q = '{d};
      pump(100);
      check("t5b_no_flip", obs_at(0), {model_check(d), d});
      check("t5b_busy_clear", inj_busy, 1'b0);

      $display("[TB] random injections");
      for (int r = 0; r < 8; r++) begin
         arm_tick = tick_no + int'($urandom_range(0, 2));
         arm_pos  = 6'($urandom_range(0, 63));
         for (int i = 0; i < 3; i++) src_q.push_back($urandom());
         pump(100);
         check("t5c_busy_clear", inj_busy, 1'b0);
      end
      check("t5c_word_cnt", word_cnt, accept_count);

      $display("[TB] reset with words in flight");
      stall_from = tick_no;
      stall_to   = tick_no + 100;
      arm_tick   = tick_no + 2;
      arm_pos    = 6'd3;
      src_q = '{$urandom(), $urandom()};
      repeat (3) apply_stimulus();
      inj_arm = 1'b0;
      check("t6_valid_before", out_valid, 1'b1);
      check("t6_busy_before", inj_busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid", out_valid, 1'b0);
      check("t6_async_data", {out_check, out_data}, 40'h0);
      check("t6_async_busy", inj_busy, 1'b0);
      check("t6_async_cnt", word_cnt, 16'd0);
      clear_model();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      out_before = out_count;
      for (int i = 0; i < 6; i++) apply_stimulus();
      check("t6_no_stale", out_count - out_before, 0);
      check("t6_word_cnt", word_cnt, 16'd0);
      check("t6_in_ready", in_ready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
